motor_cmd_scheduler: RTL and testbench

- Sits between the APB motor command register and the two PWM motor channels.
- Arbitrates between remote drive commands and a bumper-triggered avoidance manoeuvre (stop, back up, pivot).
- Slew-limits duty toward the selected target; direction reverses only at zero duty.
- Runs a command watchdog that stops the car if commands cease.

---
 rtl/motor_cmd_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_motor_cmd_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_scheduler.sv
// rtl/motor_cmd_scheduler.sv - remote/avoidance command arbiter with slew-limited PWM outputs
//
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_valid, cmd_word   remote command strobe and payload
//                         [0] en_r [1] dir_r [2] en_l [3] dir_l [15:8] duty_r [23:16] duty_l
//   bump_l, bump_r        pre-synchronised bumper levels
//   PWM_DUTY_x/EN_x/DIR_x applied per-side duty, enable and direction (x = R, L)
//   state                 IDLE=0 DRIVE=1 STOP=2 BACKUP=3 TURN=4
//   override              high while the avoidance manoeuvre owns the motors
module motor_cmd_scheduler #(
  parameter int RAMP_DIV    = 100000,
  parameter int RAMP_STEP   = 4,
  parameter int BACK_CYCLES = 50000000,
  parameter int TURN_CYCLES = 25000000,
  parameter int BACK_DUTY   = 128,
  parameter int TIMEOUT     = 100000000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  input  logic [23:0] cmd_word,
  input  logic        bump_l,
  input  logic        bump_r,
  output logic [7:0]  PWM_DUTY_R,
  output logic [7:0]  PWM_DUTY_L,
  output logic        PWM_EN_R,
  output logic        PWM_EN_L,
  output logic        PWM_DIR_R,
  output logic        PWM_DIR_L,
  output logic [2:0]  state,
  output logic        override
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_STOP   = 3'd2,
    S_BACKUP = 3'd3,
    S_TURN   = 3'd4
  } state_t;

  localparam logic [7:0] STEP  = 8'(RAMP_STEP);
  localparam logic [7:0] BDUTY = 8'(BACK_DUTY);

  state_t      cur_state, nxt_state;
  logic [31:0] tick_cnt, wd_cnt, phase_cnt;
  logic        tick, bump_any, wd_last, phase_done, bump_lat_l;
  logic        tgt_dir_r, tgt_dir_l, nxt_dir_r, nxt_dir_l;
  logic [7:0]  tgt_duty_r, tgt_duty_l, nxt_duty_r, nxt_duty_l;
  logic [8:0]  ramp_r, ramp_l;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_word[7:4];
  assign tick       = (tick_cnt == 32'(RAMP_DIV - 1));
  assign bump_any   = bump_l | bump_r;
  assign wd_last    = (wd_cnt == 32'(TIMEOUT - 1));
  assign phase_done = (cur_state == S_BACKUP) ? (phase_cnt == 32'(BACK_CYCLES - 1))
                                              : (phase_cnt == 32'(TURN_CYCLES - 1));
  assign state      = cur_state;

  // One ramp tick for one side, returned as {dir, duty}. A direction change
  // first drains duty to zero, and only then flips dir (duty stays 0 that tick).
  function automatic logic [8:0] ramp_step(input logic dir, input logic [7:0] duty,
                                           input logic tdir, input logic [7:0] tduty);
    logic [8:0] res;
    res = {dir, duty};
    if (dir != tdir) begin
      if (duty == 8'd0)     res = {tdir, 8'd0};
      else if (duty > STEP) res = {dir, duty - STEP};
      else                  res = {dir, 8'd0};
    end else if (duty < tduty) begin
      res = (tduty - duty > STEP) ? {dir, duty + STEP} : {dir, tduty};
    end else if (duty > tduty) begin
      res = (duty - tduty > STEP) ? {dir, duty - STEP} : {dir, tduty};
    end
    return res;
  endfunction

  assign ramp_r = ramp_step(PWM_DIR_R, PWM_DUTY_R, tgt_dir_r, tgt_duty_r);
  assign ramp_l = ramp_step(PWM_DIR_L, PWM_DUTY_L, tgt_dir_l, tgt_duty_l);

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Next-state logic; bumpers win over a same-cycle command
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:   if (bump_any) nxt_state = S_STOP;
                else if (cmd_valid) nxt_state = S_DRIVE;
      S_DRIVE:  if (bump_any) nxt_state = S_STOP;
                else if (!cmd_valid && wd_last) nxt_state = S_IDLE;
      S_STOP:   if (PWM_DUTY_R == 8'd0 && PWM_DUTY_L == 8'd0) nxt_state = S_BACKUP;
      S_BACKUP: if (phase_done) nxt_state = S_TURN;
      S_TURN:   if (phase_done) nxt_state = S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    override = 1'b0;
    case (cur_state)
      S_STOP, S_BACKUP, S_TURN: override = 1'b1;
      default:                  override = 1'b0;
    endcase
  end

  // Targets follow the state being entered, so they land together with it
  always_comb begin
    nxt_dir_r  = tgt_dir_r;
    nxt_dir_l  = tgt_dir_l;
    nxt_duty_r = tgt_duty_r;
    nxt_duty_l = tgt_duty_l;
    case (nxt_state)
      S_DRIVE: if (cmd_valid) begin
        nxt_dir_r  = cmd_word[1];
        nxt_dir_l  = cmd_word[3];
        nxt_duty_r = cmd_word[0] ? cmd_word[15:8]  : 8'd0;
        nxt_duty_l = cmd_word[2] ? cmd_word[23:16] : 8'd0;
      end
      S_BACKUP: begin
        nxt_dir_r  = 1'b1;
        nxt_dir_l  = 1'b1;
        nxt_duty_r = BDUTY;
        nxt_duty_l = BDUTY;
      end
      S_TURN: begin
        // Left bump (or both) pivots right: left wheel forward, right reverse
        nxt_dir_l  = ~bump_lat_l;
        nxt_dir_r  = bump_lat_l;
        nxt_duty_r = BDUTY;
        nxt_duty_l = BDUTY;
      end
      default: begin
        nxt_dir_r  = 1'b0;
        nxt_dir_l  = 1'b0;
        nxt_duty_r = 8'd0;
        nxt_duty_l = 8'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tick_cnt   <= '0;
      wd_cnt     <= '0;
      phase_cnt  <= '0;
      bump_lat_l <= 1'b0;
      tgt_dir_r  <= 1'b0;
      tgt_dir_l  <= 1'b0;
      tgt_duty_r <= 8'd0;
      tgt_duty_l <= 8'd0;
      PWM_DUTY_R <= 8'd0;
      PWM_DUTY_L <= 8'd0;
      PWM_EN_R   <= 1'b0;
      PWM_EN_L   <= 1'b0;
      PWM_DIR_R  <= 1'b0;
      PWM_DIR_L  <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + 32'd1;
      wd_cnt     <= (cur_state == S_DRIVE && !cmd_valid) ? wd_cnt + 32'd1 : '0;
      phase_cnt  <= (nxt_state != cur_state ||
                     !(cur_state == S_BACKUP || cur_state == S_TURN)) ? '0 : phase_cnt + 32'd1;
      tgt_dir_r  <= nxt_dir_r;
      tgt_dir_l  <= nxt_dir_l;
      tgt_duty_r <= nxt_duty_r;
      tgt_duty_l <= nxt_duty_l;
      if (nxt_state == S_STOP && cur_state != S_STOP) bump_lat_l <= bump_l;
      else if (cur_state == S_TURN && nxt_state == S_IDLE) bump_lat_l <= 1'b0;
      if (tick) begin
        {PWM_DIR_R, PWM_DUTY_R} <= ramp_r;
        {PWM_DIR_L, PWM_DUTY_L} <= ramp_l;
        PWM_EN_R <= (ramp_r[7:0] != 8'd0);
        PWM_EN_L <= (ramp_l[7:0] != 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb/tb_motor_cmd_scheduler.sv - self-checking bench for motor_cmd_scheduler
module tb_motor_cmd_scheduler;
  localparam int RD = 4;
  localparam int RS = 4;
  localparam int BC = 40;
  localparam int TC = 20;
  localparam int BD = 16;
  localparam int TO = 200;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_word = '0;
  logic        bump_l = 1'b0;
  logic        bump_r = 1'b0;
  logic [7:0]  PWM_DUTY_R, PWM_DUTY_L;
  logic        PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L;
  logic [2:0]  state;
  logic        override;

  int checks = 0;
  int failures = 0;

  // Behavioural reference: index 0 = right, 1 = left
  int m_state, m_tick, m_wd, m_phase;
  int m_duty[2];
  int m_tduty[2];
  bit m_dir[2];
  bit m_tdir[2];
  bit m_bl;

  motor_cmd_scheduler #(
    .RAMP_DIV(RD), .RAMP_STEP(RS), .BACK_CYCLES(BC),
    .TURN_CYCLES(TC), .BACK_DUTY(BD), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .bump_l(bump_l), .bump_r(bump_r),
    .PWM_DUTY_R(PWM_DUTY_R), .PWM_DUTY_L(PWM_DUTY_L),
    .PWM_EN_R(PWM_EN_R), .PWM_EN_L(PWM_EN_L),
    .PWM_DIR_R(PWM_DIR_R), .PWM_DIR_L(PWM_DIR_L),
    .state(state), .override(override)
  );

  always #5 PCLK = ~PCLK;

  task automatic model_targets(input bit dr, input int ur, input bit dl, input int ul);
    m_tdir[0] = dr; m_tduty[0] = ur;
    m_tdir[1] = dl; m_tduty[1] = ul;
  endtask

  task automatic model_step();
    int od[2];
    if (PRESET) begin
      m_state = 0; m_tick = 0; m_wd = 0; m_phase = 0; m_bl = 0;
      for (int s = 0; s < 2; s++) begin
        m_duty[s] = 0; m_dir[s] = 0; m_tduty[s] = 0; m_tdir[s] = 0;
      end
      return;
    end
    od[0] = m_duty[0];
    od[1] = m_duty[1];
    if (m_tick == RD - 1) begin
      m_tick = 0;
      for (int s = 0; s < 2; s++) begin
        if (m_dir[s] != m_tdir[s]) begin
          if (m_duty[s] > 0) m_duty[s] = (m_duty[s] > RS) ? m_duty[s] - RS : 0;
          else m_dir[s] = m_tdir[s];
        end else if (m_duty[s] < m_tduty[s]) begin
          m_duty[s] = (m_duty[s] + RS < m_tduty[s]) ? m_duty[s] + RS : m_tduty[s];
        end else if (m_duty[s] > m_tduty[s]) begin
          m_duty[s] = (m_duty[s] - RS > m_tduty[s]) ? m_duty[s] - RS : m_tduty[s];
        end
      end
    end else begin
      m_tick++;
    end
    case (m_state)
      0, 1: begin
        if (bump_l || bump_r) begin
          m_state = 2; m_bl = bump_l; model_targets(0, 0, 0, 0);
        end else if (cmd_valid) begin
          m_state = 1; m_wd = 0;
          model_targets(cmd_word[1], cmd_word[0] ? int'(cmd_word[15:8]) : 0,
                        cmd_word[3], cmd_word[2] ? int'(cmd_word[23:16]) : 0);
        end else if (m_state == 0) begin
          model_targets(0, 0, 0, 0);
        end else if (m_wd == TO - 1) begin
          m_state = 0; model_targets(0, 0, 0, 0);
        end else begin
          m_wd++;
        end
      end
      2: if (od[0] == 0 && od[1] == 0) begin
        m_state = 3; m_phase = 0; model_targets(1, BD, 1, BD);
      end
      3: if (m_phase == BC - 1) begin
        m_state = 4; m_phase = 0;
        if (m_bl) model_targets(1, BD, 0, BD);
        else      model_targets(0, BD, 1, BD);
      end else m_phase++;
      default: if (m_phase == TC - 1) begin
        m_state = 0; m_bl = 0; model_targets(0, 0, 0, 0);
      end else m_phase++;
    endcase
  endtask

  function automatic logic [23:0] model_vec();
    return {3'(m_state), m_state >= 2, m_dir[1], m_duty[1] != 0, 8'(m_duty[1]),
            m_dir[0], m_duty[0] != 0, 8'(m_duty[0])};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {state, override, PWM_DIR_L, PWM_EN_L, PWM_DUTY_L, PWM_DIR_R, PWM_EN_R, PWM_DUTY_R};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic strobe(input logic [23:0] w);
    cmd_valid = 1'b1; cmd_word = w;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    cycle(); cycle();
    checks++;
    if (dut_vec() !== 24'h0) begin
      failures++; $display("FAIL reset got=%h exp=000000", dut_vec());
    end
    PRESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== 24'h0) begin
        failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=000000", i, dut_vec());
      end
    end
  endtask

  task automatic test_ramp_up();
    int exp_d[3] = '{4, 8, 10};
    int idx = 0, last = 0, prev = 0;
    strobe(24'h0A0A05);
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL ramp_state got=%0d exp=1", state); end
    for (int c = 0; c < 60 && idx < 3; c++) begin
      cycle();
      if (int'(PWM_DUTY_R) != prev) begin
        checks++;
        if (PWM_DUTY_R !== 8'(exp_d[idx]) || PWM_DUTY_L !== 8'(exp_d[idx]) || PWM_EN_R !== 1'b1 ||
            PWM_EN_L !== 1'b1 || PWM_DIR_R !== 1'b0 || PWM_DIR_L !== 1'b0) begin
          failures++; $display("FAIL ramp_step idx=%0d got=%h exp_duty=%0d", idx, dut_vec(), exp_d[idx]);
        end
        if (idx > 0) begin
          checks++;
          if (c - last != RD) begin
            failures++; $display("FAIL ramp_spacing got=%0d exp=%0d", c - last, RD);
          end
        end
        last = c; prev = PWM_DUTY_R; idx++;
      end
    end
    checks++;
    if (idx != 3) begin failures++; $display("FAIL ramp_count got=%0d exp=3", idx); end
  endtask

  task automatic test_reversal();
    logic [8:0] exp_v[6] = '{9'h006, 9'h002, 9'h000, 9'h100, 9'h104, 9'h108};
    logic [8:0] prev;
    int idx = 0;
    prev = {PWM_DIR_R, PWM_DUTY_R};
    strobe(24'h0A0807);
    for (int c = 0; c < 80 && idx < 6; c++) begin
      cycle();
      checks++;
      if (PWM_DUTY_L !== 8'd10 || PWM_DIR_L !== 1'b0 || PWM_EN_L !== 1'b1) begin
        failures++; $display("FAIL rev_left c=%0d got=%h exp_duty=10 fwd", c, dut_vec());
      end
      if ({PWM_DIR_R, PWM_DUTY_R} != prev) begin
        checks++;
        if ({PWM_DIR_R, PWM_DUTY_R} !== exp_v[idx] || PWM_EN_R !== (exp_v[idx][7:0] != 8'd0)) begin
          failures++; $display("FAIL rev_right idx=%0d got=%h exp=%h", idx, {PWM_DIR_R, PWM_DUTY_R}, exp_v[idx]);
        end
        prev = {PWM_DIR_R, PWM_DUTY_R}; idx++;
      end
    end
    checks++;
    if (idx != 6) begin failures++; $display("FAIL rev_count got=%0d exp=6", idx); end
  endtask

  task automatic test_watchdog();
    int cnt = 0;
    strobe(24'h0A0807);
    while (state == 3'd1 && cnt < 300) begin cycle(); cnt++; end
    checks++;
    if (cnt != TO) begin failures++; $display("FAIL wd_cycles got=%0d exp=%0d", cnt, TO); end
    for (int c = 0; c < 60 && (PWM_DUTY_R != 0 || PWM_DUTY_L != 0); c++) begin
      cycle();
      checks++;
      if (PWM_EN_R !== (PWM_DUTY_R != 8'd0) || PWM_EN_L !== (PWM_DUTY_L != 8'd0) || state !== 3'd0) begin
        failures++; $display("FAIL wd_rampdown c=%0d got=%h", c, dut_vec());
      end
    end
    checks++;
    if (PWM_DUTY_R !== 8'd0 || PWM_DUTY_L !== 8'd0 || PWM_EN_R !== 1'b0 || PWM_EN_L !== 1'b0) begin
      failures++; $display("FAIL wd_final got=%h exp=all zero", dut_vec());
    end
  endtask

  task automatic test_bump();
    int cnt, nseen;
    int seen[4];
    int prev;
    strobe(24'h101005);
    repeat (40) cycle();
    checks++;
    if (PWM_DUTY_R !== 8'd16 || PWM_DUTY_L !== 8'd16 || PWM_DIR_R !== 1'b0 || PWM_DIR_L !== 1'b0) begin
      failures++; $display("FAIL bump_pre got=%h exp=16/16 fwd", dut_vec());
    end
    bump_l = 1'b1; cycle(); bump_l = 1'b0;
    checks++;
    if (state !== 3'd2 || override !== 1'b1) begin
      failures++; $display("FAIL bump_stop got=%0d/%b exp=2/1", state, override);
    end
    strobe(24'h0F0F0F);
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL bump_cmd_drop got=%0d exp=2", state); end
    cnt = 0;
    while (state == 3'd2 && cnt < 100) begin
      cycle(); cnt++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL stop_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (state !== 3'd3 || PWM_DUTY_R !== 8'd0 || PWM_DUTY_L !== 8'd0) begin
      failures++; $display("FAIL backup_entry got=%h exp=state 3 duty 0", dut_vec());
    end
    cnt = 0; nseen = 0; prev = 0;
    while (state == 3'd3 && cnt < 100) begin
      cnt++;
      if (int'(PWM_DUTY_R) != prev && nseen < 4) begin seen[nseen] = PWM_DUTY_R; nseen++; end
      prev = PWM_DUTY_R;
      cmd_valid = (cnt == 10); cmd_word = 24'h0F0F0F;
      cycle();
      cmd_valid = 1'b0;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL backup_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (cnt != BC) begin failures++; $display("FAIL backup_len got=%0d exp=%0d", cnt, BC); end
    checks++;
    if (nseen != 4 || seen[0] != 4 || seen[1] != 8 || seen[2] != 12 || seen[3] != 16) begin
      failures++; $display("FAIL backup_ramp got=%0d:%0d,%0d,%0d,%0d exp=4:4,8,12,16",
                           nseen, seen[0], seen[1], seen[2], seen[3]);
    end
    cnt = 0;
    while (state == 3'd4 && cnt < 100) begin
      cnt++;
      checks++;
      if (PWM_DIR_R !== 1'b1 || PWM_DUTY_R !== 8'd16 || override !== 1'b1) begin
        failures++; $display("FAIL turn_right got=%h exp=rev 16", dut_vec());
      end
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL turn_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (cnt != TC || state !== 3'd0 || override !== 1'b0) begin
      failures++; $display("FAIL turn_len got=%0d state=%0d exp=%0d state=0", cnt, state, TC);
    end
  endtask

  task automatic test_reset_mid_override();
    int cnt = 0;
    bump_r = 1'b1; cycle(); bump_r = 1'b0;
    while (state != 3'd3 && cnt < 100) begin cycle(); cnt++; end
    repeat (12) cycle();
    checks++;
    if (state !== 3'd3 || override !== 1'b1) begin
      failures++; $display("FAIL midovr_pre got=%0d/%b exp=3/1", state, override);
    end
    PRESET = 1'b1; cycle(); PRESET = 1'b0;
    checks++;
    if (dut_vec() !== 24'h0) begin
      failures++; $display("FAIL midovr_reset got=%h exp=000000", dut_vec());
    end
  endtask

  task automatic test_back_to_back();
    strobe(24'h040405);
    strobe(24'h141405);
    repeat (40) cycle();
    checks++;
    if (state !== 3'd1 || PWM_DUTY_R !== 8'd20 || PWM_DUTY_L !== 8'd20) begin
      failures++; $display("FAIL b2b got=%h exp=state 1 duty 20/20", dut_vec());
    end
  endtask

  task automatic test_random();
    bit quiet;
    for (int i = 0; i < 4000; i++) begin
      quiet = (i % 1000) < 300;
      PRESET    = ($urandom_range(0, 1999) == 0);
      cmd_valid = !quiet && ($urandom_range(0, 7) == 0);
      cmd_word  = 24'($urandom);
      bump_l    = ($urandom_range(0, 399) == 0);
      bump_r    = ($urandom_range(0, 399) == 0);
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        if (failures < 20) $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    PRESET = 1'b0; cmd_valid = 1'b0; bump_l = 1'b0; bump_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_watchdog();
    test_bump();
    test_reset_mid_override();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
